x_uart_arb: RTL and testbench
=============================

# x_uart_arb

Round-robin arbiter and serializer that shares one byte-wide UART transmitter between several word sources (delay-line snapshot, status words, etc.). It accepts one `p_length`-bit word at a time from the granted requester and sends it to the UART byte transmitter as a sequence of bytes over a valid/ready handshake. It sits between the delay-line capture logic and the byte-level UART TX.

## Interface
- `p_length`, 32, word width in bits; multiple of 8, ≥ 8
- `p_req`, 2, number of requesters; 1..16
- `i_clk`  in  1  clock
- `i_nrst`  in  1  reset, asynchronous, active-low
- `i_req_valid`  in  p_req  per-requester word valid
- `i_req_data`  in  p_req*p_length  requester k data at bits [k*p_length +: p_length]
- `o_req_ready`  out  p_req  one-hot accept strobe
- `o_byte_valid`  out  1  byte available to UART TX
- `o_byte_data`  out  8  byte to UART TX
- `i_byte_ready`  in  1  UART TX accepts byte
- `o_busy`  out  1  high when state ≠ IDLE

## Operation
- States: IDLE, HDR (only with the macro), SEND.
- Byte count `p_bytes = p_length/8`. The byte counter width is `max(1, clog2(p_bytes))`.
- **IDLE**
  - If any `i_req_valid` bit is set, grant the first set bit found searching upward from `rr_ptr`, wrapping modulo `p_req`.
  - `o_req_ready` = one-hot grant, combinational, in the same cycle. A handshake completes when valid & ready.
  - On grant:
    - latch `i_req_data[grant]` into the word register;
    - latch the grant index;
    - set `rr_ptr` to (grant+1) mod `p_req`;
    - clear the byte counter;
    - go to SEND (or HDR).
  - If no bit is set, stay in IDLE. `rr_ptr` is unchanged.
- **HDR**
  - `o_byte_valid`=1, `o_byte_data` = `8'hA0 | idx[3:0]`.
  - On `i_byte_ready`, go to SEND.
- **SEND**
  - `o_byte_valid`=1, `o_byte_data` = `word[8*cnt +: 8]`. Bytes go LSB first.
  - On `i_byte_ready`: if `cnt == p_bytes-1`, go to IDLE; otherwise increment `cnt`.
- `o_req_ready` is 0 outside IDLE. Requester data is sampled only at acceptance; later changes are ignored.
- Holding rule: while `o_byte_valid` is high and `i_byte_ready` is low, `o_byte_data` stays stable and `o_byte_valid` does not drop.
- `p_req`=1: arbitration degenerates to a fixed grant, and `rr_ptr` stays 0.

## Timing
- Reset values:
  - state IDLE; `rr_ptr`=0; word register 0; counter 0;
  - `o_byte_valid`=0, `o_byte_data`=0, `o_busy`=0, `o_req_ready`=0 while in reset.
- Latency: word accepted in cycle N; first byte is valid in cycle N+1.
- With `i_byte_ready` held high:
  - a word occupies exactly `p_bytes` cycles in SEND (+1 with HDR);
  - one IDLE bubble cycle is required between words, so the next grant cannot occur earlier than the cycle after the last byte handshake.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others see `o_req_ready`=0 and must hold valid.
- Reset mid-operation: asynchronous clear to IDLE. The partial word is dropped and not resumed. The requester already saw its accept, so the word is lost by design.
- `i_byte_ready` high while `o_byte_valid` is low: ignored.

## Configuration
- `X_UART_ARB_HEADER_EN` defined:
  - the HDR state is compiled in;
  - each word is preceded by header byte `8'hA0 | requester index`;
  - a word takes `p_bytes+1` byte handshakes.
- Undefined:
  - no HDR state; IDLE goes directly to SEND;
  - a word takes exactly `p_bytes` handshakes.

## Test plan
- Reset, no requests, `i_byte_ready`=1 → `o_byte_valid`=0, `o_busy`=0, `o_req_ready`=0 for 20 cycles.
- Single requester 0 with data `32'h44332211`, ready=1, macro off → `o_req_ready`=2'b01 for one cycle; bytes 11, 22, 33, 44 on the next 4 cycles; IDLE afterwards.
- Both requesters valid continuously, with data 0: `32'hA3A2A1A0` and 1: `32'hB3B2B1B0` → grants alternate 0,1,0,1; byte streams A0..A3, then B0..B3; one bubble cycle between words.
- Backpressure: `i_byte_ready` low for 5 cycles during byte 2 → `o_byte_data`=33 held stable with valid high; the stream resumes 33, 44.
- Macro on, requester 1 sends `32'h0000BEEF` → bytes A1, EF, BE, 00, 00.
- `i_nrst` asserted after byte 1 of a word → outputs return to reset values immediately; after release, a new request from requester 1 is granted first (`rr_ptr`=0 scan finds 1 only if 0 is idle), and requester 0 is granted first if both are valid.

Source files
------------

// File: rtl/x_uart_arb.sv
// Round-robin arbiter that serializes one p_length-bit word at a time into a byte stream, LSB first.
// Optional per-word header byte (8'hA0 | requester index) when X_UART_ARB_HEADER_EN is defined.
module x_uart_arb #(
  parameter int p_length = 32,
  parameter int p_req    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic [p_req-1:0]           i_req_valid,
  input  logic [p_req*p_length-1:0]  i_req_data,
  output logic [p_req-1:0]           o_req_ready,
  output logic                       o_byte_valid,
  output logic [7:0]                 o_byte_data,
  input  logic                       i_byte_ready,
  output logic                       o_busy
);

  localparam int p_bytes = p_length / 8;
  localparam int CW      = (p_bytes > 1) ? $clog2(p_bytes) : 1;
  localparam int PW      = (p_req > 1) ? $clog2(p_req) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(p_bytes - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef X_UART_ARB_HEADER_EN
  localparam logic [1:0] S_HDR  = 2'd1;
`endif
  localparam logic [1:0] S_SEND = 2'd2;

  logic [1:0]          r_state;
  logic [PW-1:0]       r_rr_ptr;
  logic [p_length-1:0] r_word;
  logic [CW-1:0]       r_cnt;
`ifdef X_UART_ARB_HEADER_EN
  logic [PW-1:0]       r_idx;
`endif

  logic                w_any;
  logic [PW-1:0]       w_grant;
  logic [p_req-1:0]    w_oh;
  logic [PW-1:0]       w_ptr_nxt;
  logic [p_length-1:0] w_sel_data;

  // Round-robin search upward from r_rr_ptr; the first hit wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_oh    = '0;
    for (int i = 0; i < p_req; i++) begin
      int   j;
      logic hit;
      j = (int'(r_rr_ptr) + i >= p_req) ? int'(r_rr_ptr) + i - p_req : int'(r_rr_ptr) + i;
      hit      = !w_any && i_req_valid[j];
      w_grant  = hit ? PW'(j) : w_grant;
      w_oh[j]  = w_oh[j] | hit;
      w_any    = w_any | hit;
    end
  end

  assign w_ptr_nxt  = (int'(w_grant) + 1 >= p_req) ? '0 : PW'(int'(w_grant) + 1);
  assign w_sel_data = i_req_data[int'(w_grant)*p_length +: p_length];

  // Grant is only offered in IDLE and never while reset is applied.
  assign o_req_ready = ((r_state == S_IDLE) && i_nrst) ? w_oh : '0;
  assign o_busy      = (r_state != S_IDLE);

  // Arbitration state, word capture and byte counter.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_word   <= '0;
      r_cnt    <= '0;
`ifdef X_UART_ARB_HEADER_EN
      r_idx    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_word   <= w_sel_data;
            r_rr_ptr <= w_ptr_nxt;
            r_cnt    <= '0;
`ifdef X_UART_ARB_HEADER_EN
            r_idx    <= w_grant;
            r_state  <= S_HDR;
`else
            r_state  <= S_SEND;
`endif
          end else begin
            r_state  <= S_IDLE;
          end
        end
`ifdef X_UART_ARB_HEADER_EN
        S_HDR: begin
          if (i_byte_ready) begin
            r_state <= S_SEND;
          end else begin
            r_state <= S_HDR;
          end
        end
`endif
        S_SEND: begin
          if (i_byte_ready) begin
            if (r_cnt == LAST_CNT) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
            end
          end else begin
            r_state <= S_SEND;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte output decode; depends only on registers so it holds under backpressure.
  always_comb begin
    o_byte_valid = 1'b0;
    o_byte_data  = 8'h00;
    case (r_state)
`ifdef X_UART_ARB_HEADER_EN
      S_HDR: begin
        o_byte_valid = 1'b1;
        o_byte_data  = 8'hA0 | {4'h0, 4'(r_idx)};
      end
`endif
      S_SEND: begin
        o_byte_valid = 1'b1;
        o_byte_data  = r_word[{r_cnt, 3'b000} +: 8];
      end
      default: begin
        o_byte_valid = 1'b0;
        o_byte_data  = 8'h00;
      end
    endcase
  end

endmodule

// File: tb/tb_x_uart_arb.sv
// Directed bench for x_uart_arb (p_length=32, p_req=2); header bytes expected when
// X_UART_ARB_HEADER_EN is defined.
module tb_x_uart_arb;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int last_idx = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  x_uart_arb #(.p_length(32), .p_req(2)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_byte_valid (byte_valid),
    .o_byte_data  (byte_data),
    .i_byte_ready (byte_ready),
    .o_busy       (busy)
  );

  // Expected byte stream for one word from requester idx.
  function automatic void build_exp(input int idx, input logic [31:0] wd);
    exp_q.delete();
    last_idx = idx;
`ifdef X_UART_ARB_HEADER_EN
    exp_q.push_back(8'hA0 | 8'(idx));
`endif
    for (int k = 0; k < 4; k++) exp_q.push_back(wd[8*k +: 8]);
  endfunction

  task automatic test_reset();
    nrst = 1'b0; req_valid = 2'b00; req_data = 64'h0; byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (byte_valid !== 1'b0 || byte_data !== 8'h00 || busy !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b data=%h busy=%b ready=%b want 0 00 0 00",
               byte_valid, byte_data, busy, req_ready);
    end
    @(negedge clk); nrst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if (byte_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_no_req cyc%0d: got valid=%b busy=%b ready=%b want 0 0 00",
                 c, byte_valid, busy, req_ready);
      end
    end
  endtask

  task automatic test_alternate();
    logic [1:0]  g;
    logic [31:0] wd;
    for (int w = 0; w < 4; w++) begin
      g  = (w % 2 == 0) ? 2'b01 : 2'b10;
      wd = (w % 2 == 0) ? 32'hA3A2A1A0 : 32'hB3B2B1B0;
      @(negedge clk);
      if (w == 0) begin
        req_data  = {32'hB3B2B1B0, 32'hA3A2A1A0};
        req_valid = 2'b11;
      end
      #1;
      n_checks++;
      if (req_ready !== g || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL alt_grant w%0d: got ready=%b busy=%b want ready=%b busy=0", w, req_ready, busy, g);
      end
      @(posedge clk);
      build_exp(w % 2, wd);
      for (int b = 0; b < exp_q.size(); b++) begin
        @(negedge clk);
        if (w == 3 && b == exp_q.size() - 1) req_valid = 2'b00;
        #1;
        n_checks++;
        if (byte_valid !== 1'b1 || byte_data !== exp_q[b] || req_ready !== 2'b00) begin
          n_fail++;
          $display("FAIL alt_byte req%0d w%0d b%0d: got valid=%b data=%h ready=%b want 1 %h 00",
                   last_idx, w, b, byte_valid, byte_data, req_ready, exp_q[b]);
        end
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_end_idle: got busy=%b valid=%b ready=%b want 0 0 00", busy, byte_valid, req_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    req_data[31:0] = 32'h44332211; req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_grant: got ready=%b want 01", req_ready);
    end
    @(posedge clk);
    build_exp(0, 32'h44332211);
    for (int b = 0; b < exp_q.size(); b++) begin
      @(negedge clk);
      if (b == exp_q.size() - 1) req_valid = 2'b00;
      #1;
      n_checks++;
      if (byte_valid !== 1'b1 || byte_data !== exp_q[b] || req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_byte req%0d b%0d: got valid=%b data=%h ready=%b busy=%b want 1 %h 00 1",
                 last_idx, b, byte_valid, byte_data, req_ready, busy, exp_q[b]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end_idle: got busy=%b valid=%b want 0 0", busy, byte_valid);
    end
  endtask

  task automatic test_backpressure();
    int stall_b;
    @(negedge clk);
    req_data[31:0] = 32'h44332211; req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_grant: got ready=%b want 01", req_ready);
    end
    @(posedge clk);
    build_exp(0, 32'h44332211);
    stall_b = exp_q.size() - 2;
    for (int b = 0; b < exp_q.size(); b++) begin
      if (b == stall_b) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk); byte_ready = 1'b0; #1;
          n_checks++;
          if (byte_valid !== 1'b1 || byte_data !== exp_q[b]) begin
            n_fail++;
            $display("FAIL bp_hold s%0d: got valid=%b data=%h want 1 %h", s, byte_valid, byte_data, exp_q[b]);
          end
        end
      end
      @(negedge clk);
      byte_ready = 1'b1; req_valid = 2'b00;
      #1;
      n_checks++;
      if (byte_valid !== 1'b1 || byte_data !== exp_q[b]) begin
        n_fail++;
        $display("FAIL bp_byte req%0d b%0d: got valid=%b data=%h want 1 %h",
                 last_idx, b, byte_valid, byte_data, exp_q[b]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end_idle: got busy=%b valid=%b want 0 0", busy, byte_valid);
    end
  endtask

  task automatic test_beef();
    @(negedge clk);
    req_data[63:32] = 32'h0000BEEF; req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL beef_grant: got ready=%b want 10", req_ready);
    end
    @(posedge clk);
    build_exp(1, 32'h0000BEEF);
    for (int b = 0; b < exp_q.size(); b++) begin
      @(negedge clk); req_valid = 2'b00; #1;
      n_checks++;
      if (byte_valid !== 1'b1 || byte_data !== exp_q[b]) begin
        n_fail++;
        $display("FAIL beef_byte req%0d b%0d: got valid=%b data=%h want 1 %h",
                 last_idx, b, byte_valid, byte_data, exp_q[b]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL beef_end_idle: got busy=%b valid=%b want 0 0", busy, byte_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_data = {32'h0000BEEF, 32'h44332211}; req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_grant: got ready=%b want 01", req_ready);
    end
    @(posedge clk);
    build_exp(0, 32'h44332211);
    @(negedge clk); #1;
    n_checks++;
    if (byte_valid !== 1'b1 || byte_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rst_mid_first: got valid=%b data=%h want 1 %h", byte_valid, byte_data, exp_q[0]);
    end
    @(negedge clk);
    nrst = 1'b0; req_valid = 2'b11;
    #1;
    n_checks++;
    if (byte_valid !== 1'b0 || byte_data !== 8'h00 || busy !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got valid=%b data=%h busy=%b ready=%b want 0 00 0 00",
               byte_valid, byte_data, busy, req_ready);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_ptr_cleared: got ready=%b want 01", req_ready);
    end
    @(posedge clk);
    for (int b = 0; b < exp_q.size(); b++) begin
      @(negedge clk); req_valid = 2'b00; #1;
      n_checks++;
      if (byte_valid !== 1'b1 || byte_data !== exp_q[b]) begin
        n_fail++;
        $display("FAIL rst_new_word req%0d b%0d: got valid=%b data=%h want 1 %h",
                 last_idx, b, byte_valid, byte_data, exp_q[b]);
      end
    end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req1_grant: got ready=%b busy=%b want 10 0", req_ready, busy);
    end
    @(posedge clk);
    build_exp(1, 32'h0000BEEF);
    for (int b = 0; b < exp_q.size(); b++) begin
      @(negedge clk); req_valid = 2'b00; #1;
      n_checks++;
      if (byte_valid !== 1'b1 || byte_data !== exp_q[b]) begin
        n_fail++;
        $display("FAIL rst_req1_byte req%0d b%0d: got valid=%b data=%h want 1 %h",
                 last_idx, b, byte_valid, byte_data, exp_q[b]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_end_idle: got busy=%b valid=%b want 0 0", busy, byte_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_backpressure();
    test_beef();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
